lfsr_burst_ctrl: RTL and testbench

Next-generation controller for the LFSR random engine. It adds a seed-load phase, a burst mode that emits exactly N values, and a valid/ready output handshake. The LFSR advances only when a value is consumed. It sits between the I/O interface and the random-engine datapath and drives the datapath's lfsr_en and seed_load controls.

---
 rtl/lfsr_ctrl_pkg.sv | 17 +
 rtl/Register.sv | 20 ++
 rtl/lfsr_burst_counter.sv | 34 +++
 rtl/lfsr_burst_ctrl.sv | 143 ++++++++++++++
 tb/tb_lfsr_burst_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and constants for the LFSR burst controller.
// State encoding, mode values and default counter width.
package lfsr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic MODE_FREE  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/Register.sv
// Generic enabled register with synchronous active-high reset.
// Reset value is all zeros.
module Register #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/lfsr_burst_counter.sv
// Handshake counter with clear, increment and a flag
// for the final value of a burst of length len.
module lfsr_burst_counter
  import lfsr_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic             cnt_en;
  logic [CNT_W-1:0] cnt_d;

  assign cnt_en = clr | inc;
  assign cnt_d  = clr ? '0 : count + CNT_W'(1);

  Register #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .d   (cnt_d),
    .q   (count)
  );

  // next handshake brings count up to len
  assign last = (count == len - CNT_W'(1));

endmodule

// File: rtl/lfsr_burst_ctrl.sv
// LFSR engine controller: seed load, free-run/burst, valid/ready.
// Optional stall watchdog: LFSR_BURST_CTRL_STALL_WATCHDOG_EN.
module lfsr_burst_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int STALL_LIMIT = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             reseed,
  input  logic [CNT_W-1:0] burst_len,
  output logic             out_val,
  input  logic             out_rdy,
  output logic             active,
  output logic             lfsr_en,
  output logic             seed_load,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             error
);

  state_e           state_q, state_d;
  logic             mode_q;
  logic [CNT_W-1:0] len_q;
  logic             clr, inc, last;
  logic             stall_hit, wd_err;

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  Register #(.W(1)) u_mode (
    .clk (clk),
    .rst (rst),
    .en  (clr),
    .d   (mode),
    .q   (mode_q)
  );

  Register #(.W(CNT_W)) u_len (
    .clk (clk),
    .rst (rst),
    .en  (clr),
    .d   (burst_len),
    .q   (len_q)
  );

  lfsr_burst_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (inc),
    .len   (len_q),
    .count (count),
    .last  (last)
  );

`ifdef LFSR_BURST_CTRL_STALL_WATCHDOG_EN
  localparam int SW = $clog2(STALL_LIMIT + 1);

  logic [SW-1:0] stall_q;

  assign stall_hit = (state_q == RUN) && !out_rdy &&
                     (stall_q == SW'(STALL_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || out_rdy || state_d != RUN)
      stall_q <= '0;
    else
      stall_q <= stall_q + SW'(1);
  end
`else
  logic wd_unused;

  assign stall_hit = 1'b0;
  assign wd_unused = (STALL_LIMIT > 0);
`endif

  assign error = wd_err;

  // rst masks every control so a reset cycle never advances the LFSR
  always_comb begin
    state_d   = state_q;
    active    = 1'b0;
    out_val   = 1'b0;
    lfsr_en   = 1'b0;
    seed_load = 1'b0;
    done      = 1'b0;
    clr       = 1'b0;
    inc       = 1'b0;
    wd_err    = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            clr = 1'b1;
            if (reseed)
              state_d = SEED;
            else if (mode == MODE_BURST && burst_len == '0)
              state_d = DONE;
            else
              state_d = RUN;
          end
        end
        SEED: begin
          active    = 1'b1;
          seed_load = 1'b1;
          if (mode_q == MODE_BURST && len_q == '0)
            state_d = DONE;
          else
            state_d = RUN;
        end
        RUN: begin
          active  = 1'b1;
          out_val = 1'b1;
          lfsr_en = out_rdy;
          inc     = out_rdy;
          if (out_rdy && mode_q != MODE_FREE && last)
            state_d = DONE;
          else if (stop)
            state_d = IDLE;
          else if (stall_hit) begin
            wd_err  = 1'b1;
            state_d = IDLE;
          end
        end
        DONE: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Bench for lfsr_burst_ctrl: directed vector table, then random
// stimulus against a behavioural model.
module tb_lfsr_burst_ctrl;

  localparam int CW = 16;
  localparam int SL = 8;
`ifdef LFSR_BURST_CTRL_STALL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  // flag order: active, out_val, lfsr_en, seed_load, done, error
  localparam logic [5:0] FI = 6'b000000;
  localparam logic [5:0] FS = 6'b100100;
  localparam logic [5:0] FR = 6'b110000;
  localparam logic [5:0] FE = 6'b111000;
  localparam logic [5:0] FD = 6'b000010;
  localparam logic [5:0] FW = {5'b11000, WD};
  localparam logic [5:0] FX = WD ? FI : FR;

  logic          clk = 1'b0;
  logic          rst, start, stop, mode, reseed, out_rdy;
  logic [CW-1:0] burst_len;
  logic          out_val, active, lfsr_en, seed_load, done, error;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          rst, start, stop, mode, reseed, rdy;
    logic [CW-1:0] len;
    logic [5:0]    ef;
    logic [CW-1:0] ec;
  } vec_t;

  vec_t tbl[$];

  lfsr_burst_ctrl #(.CNT_W(CW), .STALL_LIMIT(SL)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .reseed    (reseed),
    .burst_len (burst_len),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .active    (active),
    .lfsr_en   (lfsr_en),
    .seed_load (seed_load),
    .done      (done),
    .count     (count),
    .error     (error)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic r, s, p, m, rs, rd,
    input int l,
    input logic [5:0] f,
    input int c
  );
    vec_t v;
    v.rst = r; v.start = s; v.stop = p;
    v.mode = m; v.reseed = rs; v.rdy = rd;
    v.len = CW'(l); v.ef = f; v.ec = CW'(c);
    return v;
  endfunction

  task automatic drive(
    input logic r, s, p, m, rs, rd,
    input logic [CW-1:0] l
  );
    rst = r; start = s; stop = p;
    mode = m; reseed = rs; out_rdy = rd;
    burst_len = l;
  endtask

  task automatic check(
    input string nm,
    input logic [5:0] ef,
    input logic [CW-1:0] ec
  );
    logic [5:0] got;
    got = {active, out_val, lfsr_en, seed_load, done, error};
    total++;
    if (got !== ef || count !== ec) begin
      bad++;
      $display("FAIL %s: got flags=%b count=%0d, want flags=%b count=%0d",
               nm, got, count, ef, ec);
    end
  endtask

  // behavioural model
  bit m_seed, m_run, m_done, m_mode;
  int m_count, m_len, m_stall;

  task automatic model_step(
    input logic r, s, p, m, rs, rd,
    input int l
  );
    if (r) begin
      m_seed = 0; m_run = 0; m_done = 0;
      m_count = 0; m_stall = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_seed) begin
      m_seed = 0;
      if (m_mode && m_len == 0) m_done = 1;
      else m_run = 1;
    end else if (m_run) begin
      if (rd) begin
        m_count = (m_count + 1) % (1 << CW);
        m_stall = 0;
        if (m_mode && m_count == m_len) begin
          m_run = 0; m_done = 1;
        end else if (p) m_run = 0;
      end else if (p) begin
        m_run = 0;
      end else begin
        m_stall++;
        if (WD && m_stall == SL) m_run = 0;
      end
      if (!m_run) m_stall = 0;
    end else if (s) begin
      m_mode = m; m_len = l; m_count = 0; m_stall = 0;
      if (rs) m_seed = 1;
      else if (m && l == 0) m_done = 1;
      else m_run = 1;
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, '0);
    repeat (2) @(posedge clk);
    #1;

    // burst with reseed, len 4
    tbl.push_back(mk(1,0,0,0,0,0, 0, FI,0));
    tbl.push_back(mk(0,1,0,1,1,1, 4, FI,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FS,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FE,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FE,1));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FE,2));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FE,3));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FD,4));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FI,4));
    // free-run, rdy 1,0,1,1 then stop
    tbl.push_back(mk(0,1,0,0,0,0, 0, FI,4));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FE,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0, FR,1));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FE,1));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FE,2));
    tbl.push_back(mk(0,0,1,0,0,0, 0, FR,3));
    tbl.push_back(mk(0,0,0,0,0,0, 0, FI,3));
    // burst len 0
    tbl.push_back(mk(0,1,0,1,0,1, 0, FI,3));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FD,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FI,0));
    // stop with completing handshake
    tbl.push_back(mk(0,1,0,1,0,1, 2, FI,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FE,0));
    tbl.push_back(mk(0,0,1,0,0,1, 0, FE,1));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FD,2));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FI,2));
    // stop with first handshake
    tbl.push_back(mk(0,1,0,1,0,1, 2, FI,2));
    tbl.push_back(mk(0,0,1,0,0,1, 0, FE,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FI,1));
    // reset mid-burst at count 5
    tbl.push_back(mk(0,1,0,1,0,1,10, FI,1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,0,0,0,1, 0, FE,i));
    tbl.push_back(mk(1,0,0,0,0,1, 0, FI,5));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FI,0));
    tbl.push_back(mk(0,1,0,1,0,1, 1, FI,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FE,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FD,1));
    tbl.push_back(mk(0,0,0,0,0,1, 0, FI,1));
    // stall in free-run
    tbl.push_back(mk(0,1,0,0,0,0, 0, FI,1));
    for (int i = 0; i < SL - 1; i++)
      tbl.push_back(mk(0,0,0,0,0,0, 0, FR,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0, FW,0));
    tbl.push_back(mk(0,0,1,0,0,0, 0, FX,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0, FI,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].stop,
            tbl[i].mode, tbl[i].reseed, tbl[i].rdy, tbl[i].len);
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].ef, tbl[i].ec);
      @(posedge clk);
      #1;
    end

    m_seed = 0; m_run = 0; m_done = 0; m_mode = 0;
    m_count = 0; m_len = 0; m_stall = 0;
    for (int i = 0; i < 3000; i++) begin
      logic r, s, p, m, rs, rd;
      int l, stall_rate;
      logic [5:0] ef;
      r  = (i == 0) || ($urandom_range(127) == 0);
      s  = ($urandom_range(2) == 0);
      p  = ($urandom_range(19) == 0);
      m  = 1'($urandom);
      rs = 1'($urandom);
      stall_rate = (i / 500) % 2 == 1 ? 1 : 3;
      rd = ($urandom_range(stall_rate) != 0);
      l  = $urandom_range(6);
      ef = '0;
      if (!r) begin
        ef[5] = m_seed | m_run;
        ef[4] = m_run;
        ef[3] = m_run & rd;
        ef[2] = m_seed;
        ef[1] = m_done;
        ef[0] = WD && m_run && !rd && !p && (m_stall + 1 == SL);
      end
      drive(r, s, p, m, rs, rd, CW'(l));
      @(negedge clk);
      check($sformatf("rnd%0d", i), ef, CW'(m_count));
      @(posedge clk);
      #1;
      model_step(r, s, p, m, rs, rd, l);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
